des_round_ctrl: RTL and testbench

Iterative DES round sequencer. It drives the control inputs of the single-round DES datapath, which holds the L/R registers, the C/D key registers, the E-expansion, the eight S-boxes and the P-permutation. It accepts one 64-bit block job per handshake and steps the datapath through load, 16 rounds and output, including the per-round key-rotation schedule for both encrypt and decrypt. It holds no data itself; it owns only sequencing, handshakes and the shift schedule.

---
 rtl/des_pkg.sv | 34 +++
 rtl/des_key_sched_lut.sv | 24 ++
 rtl/des_round_ctrl.sv | 86 ++++++++
 tb/tb_des_round_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared types and constants for the iterative DES round sequencer and its
// key-schedule lookup.
package des_pkg;

  localparam int DES_ROUNDS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SHIFT_0 = 2'b00,
    SHIFT_1 = 2'b01,
    SHIFT_2 = 2'b10
  } shift_t;

  // Bit n set = round n rotates by one (every other round rotates by two,
  // except the decrypt zero-shift round).
  localparam logic [15:0] ENC_ONE_MASK  = 16'h8103;
  localparam logic [15:0] DEC_ONE_MASK  = 16'h8102;
  localparam logic [15:0] DEC_ZERO_MASK = 16'h0001;

  // Datapath strobes decoded from the sequencer state.
  typedef struct packed {
    logic load;
    logic round_en;
    logic fin;
    logic out_valid;
  } dp_ctrl_t;

endpackage

// File: rtl/des_key_sched_lut.sv
// C/D rotate amount per round for encrypt (left) and decrypt (right).
module des_key_sched_lut
  import des_pkg::*;
(
  input  logic       i_decrypt,
  input  logic [3:0] i_idx,
  input  logic       i_en,
  output logic [1:0] o_key_shift
);

  logic [15:0] one_mask;

  assign one_mask = i_decrypt ? DEC_ONE_MASK : ENC_ONE_MASK;

  always_comb begin
    o_key_shift = SHIFT_0;
    if (i_en) begin
      if (i_decrypt && DEC_ZERO_MASK[i_idx]) o_key_shift = SHIFT_0;
      else if (one_mask[i_idx])              o_key_shift = SHIFT_1;
      else                                   o_key_shift = SHIFT_2;
    end
  end

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES round sequencer: load, 16 rounds, output handshake. Every
// output is a decode of registered state, so no input reaches an output.
module des_round_ctrl
  import des_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start_valid,
  output logic       o_start_ready,
  input  logic       i_decrypt,
  output logic       o_load,
  output logic       o_round_en,
  output logic [3:0] o_round_idx,
  output logic [1:0] o_key_shift,
  output logic       o_key_dir,
  output logic       o_final,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic       o_busy
);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       mode, mode_nxt;
  dp_ctrl_t   ctrl;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      mode  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      mode  <= mode_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode;
    case (state)
      IDLE: if (i_start_valid) begin
        mode_nxt  = i_decrypt;
        state_nxt = LOAD;
      end
      LOAD: begin
        cnt_nxt   = 4'd0;
        state_nxt = ROUND;
      end
      ROUND: begin
        // 4-bit counter wraps 15 -> 0 on the way out.
        cnt_nxt = cnt + 4'd1;
        if (cnt == 4'(DES_ROUNDS - 1)) state_nxt = OUT;
      end
      OUT: if (i_out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ctrl           = '0;
    ctrl.load      = (state == LOAD);
    ctrl.round_en  = (state == ROUND);
    ctrl.fin       = (state == ROUND) && (cnt == 4'(DES_ROUNDS - 1));
    ctrl.out_valid = (state == OUT);
  end

  assign o_start_ready = (state == IDLE);
  assign o_busy        = (state != IDLE);
  assign o_load        = ctrl.load;
  assign o_round_en    = ctrl.round_en;
  assign o_final       = ctrl.fin;
  assign o_out_valid   = ctrl.out_valid;
  assign o_round_idx   = ctrl.round_en ? cnt : 4'd0;
  assign o_key_dir     = mode;

  des_key_sched_lut u_lut (
    .i_decrypt  (mode),
    .i_idx      (cnt),
    .i_en       (ctrl.round_en),
    .o_key_shift(o_key_shift)
  );

endmodule

// File: tb/tb_des_round_ctrl.sv
// Directed bench for des_round_ctrl: encrypt/decrypt schedules, OUT
// back-pressure, async reset mid-round and mode latching.
module tb_des_round_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_start_valid = 1'b0;
  logic       o_start_ready;
  logic       i_decrypt = 1'b0;
  logic       o_load;
  logic       o_round_en;
  logic [3:0] o_round_idx;
  logic [1:0] o_key_shift;
  logic       o_key_dir;
  logic       o_final;
  logic       o_out_valid;
  logic       i_out_ready = 1'b0;
  logic       o_busy;

  int n_chk = 0;
  int n_err = 0;

  int enc_sh [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int dec_sh [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  always #5 i_clk = ~i_clk;

  des_round_ctrl dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start_valid(i_start_valid),
    .o_start_ready(o_start_ready),
    .i_decrypt    (i_decrypt),
    .o_load       (o_load),
    .o_round_en   (o_round_en),
    .o_round_idx  (o_round_idx),
    .o_key_shift  (o_key_shift),
    .o_key_dir    (o_key_dir),
    .o_final      (o_final),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_busy       (o_busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " start_ready"}, int'(o_start_ready), 1);
    chk({tag, " load"},        int'(o_load), 0);
    chk({tag, " round_en"},    int'(o_round_en), 0);
    chk({tag, " round_idx"},   int'(o_round_idx), 0);
    chk({tag, " key_shift"},   int'(o_key_shift), 0);
    chk({tag, " final"},       int'(o_final), 0);
    chk({tag, " out_valid"},   int'(o_out_valid), 0);
    chk({tag, " busy"},        int'(o_busy), 0);
  endtask

  // Start handshake, LOAD cycle, 16 rounds; leaves the DUT in OUT sampled at
  // a negedge. toggle flips i_decrypt every cycle after the handshake.
  task automatic run_job(input string tag, input logic dec, input logic toggle);
    int sum = 0;
    int exp_sh;
    @(negedge i_clk);
    chk({tag, " ready pre"}, int'(o_start_ready), 1);
    i_start_valid = 1'b1;
    i_decrypt     = dec;
    @(negedge i_clk);
    i_start_valid = 1'b0;
    if (toggle) i_decrypt = ~i_decrypt;
    chk({tag, " load"},       int'(o_load), 1);
    chk({tag, " load busy"},  int'(o_busy), 1);
    chk({tag, " load shift"}, int'(o_key_shift), 0);
    chk({tag, " load ready"}, int'(o_start_ready), 0);
    for (int k = 0; k < 16; k++) begin
      @(negedge i_clk);
      if (toggle) i_decrypt = ~i_decrypt;
      exp_sh = dec ? dec_sh[k] : enc_sh[k];
      sum += int'(o_key_shift);
      chk($sformatf("%s r%0d en", tag, k),    int'(o_round_en), 1);
      chk($sformatf("%s r%0d idx", tag, k),   int'(o_round_idx), k);
      chk($sformatf("%s r%0d shift", tag, k), int'(o_key_shift), exp_sh);
      chk($sformatf("%s r%0d dir", tag, k),   int'(o_key_dir), int'(dec));
      chk($sformatf("%s r%0d final", tag, k), int'(o_final), (k == 15) ? 1 : 0);
      chk($sformatf("%s r%0d load", tag, k),  int'(o_load), 0);
    end
    chk({tag, " shift sum"}, sum, dec ? 27 : 28);
    @(negedge i_clk);
    chk({tag, " out_valid"}, int'(o_out_valid), 1);
    chk({tag, " out en"},    int'(o_round_en), 0);
    chk({tag, " out final"}, int'(o_final), 0);
    chk({tag, " out shift"}, int'(o_key_shift), 0);
    chk({tag, " out idx"},   int'(o_round_idx), 0);
  endtask

  // Hold i_out_ready low for hold cycles (with a spurious start request),
  // then complete the output handshake and confirm the return to IDLE.
  task automatic drain(input string tag, input int hold);
    i_start_valid = (hold > 0);
    for (int k = 0; k < hold; k++) begin
      @(negedge i_clk);
      chk($sformatf("%s hold%0d valid", tag, k), int'(o_out_valid), 1);
      chk($sformatf("%s hold%0d ready", tag, k), int'(o_start_ready), 0);
      chk($sformatf("%s hold%0d load", tag, k),  int'(o_load), 0);
    end
    i_start_valid = 1'b0;
    i_out_ready   = 1'b1;
    @(negedge i_clk);
    i_out_ready = 1'b0;
    chk_idle({tag, " post"});
  endtask

  initial begin
    #2;
    chk_idle("reset");
    chk("reset dir", int'(o_key_dir), 0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    run_job("enc", 1'b0, 1'b0);
    drain("enc", 0);

    run_job("dec", 1'b1, 1'b0);
    chk("dec dir held", int'(o_key_dir), 1);
    drain("dec", 10);

    // Back-to-back job right after the drain, with i_decrypt toggling.
    run_job("tog", 1'b0, 1'b1);
    drain("tog", 0);

    run_job("tog1", 1'b1, 1'b1);
    drain("tog1", 0);

    // Async reset in the round-7 cycle, away from any clock edge.
    @(negedge i_clk);
    i_start_valid = 1'b1;
    i_decrypt     = 1'b1;
    @(negedge i_clk);
    i_start_valid = 1'b0;
    repeat (8) @(negedge i_clk);
    chk("mid idx", int'(o_round_idx), 7);
    #2 i_rst_n = 1'b0;
    #1;
    chk_idle("async");
    chk("async dir", int'(o_key_dir), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    chk_idle("released");

    run_job("after", 1'b0, 1'b0);
    drain("after", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
